// File: rtl/cpu_pkg.sv
// Shared types for the multicycle core's memory-port arbiter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  localparam int ARB_STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory handshake bundle for mem_port_arbiter.
// Handshake: a requester holds req plus its fields until a one-cycle ack; the
// arbiter holds mem_req plus its fields until a one-cycle mem_ack.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] rd_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter's view.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_ack, d_ack, rd_data, mem_req, mem_we, mem_addr, mem_wdata
    );

    // The CPU requesters and the memory, seen from outside the arbiter.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_ack, d_ack, rd_data, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select: data first, fetch forced once the data streak
// has reached MAX_D_STREAK while fetch waits. Also yields the next streak value.
module arb_pick
  import cpu_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                    if_req,
    input  logic                    d_req,
    input  logic [ARB_STREAK_W-1:0] streak,
    output arb_owner_t              winner,
    output logic [ARB_STREAK_W-1:0] streak_nxt
);
    localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(MAX_D_STREAK);

    logic force_if;

    always_comb begin
        force_if   = if_req && (streak == STREAK_MAX);
        winner     = OWN_NONE;
        streak_nxt = '0;
        if (d_req && !force_if) begin
            winner = OWN_D;
            // Data can only win below the limit, so the increment saturates by construction.
            if (if_req) streak_nxt = streak + 1'b1;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data requesters.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYC cycles and sets sticky err.
module mem_port_arbiter
  import cpu_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                err,
    output arb_state_t          state_dbg
);
    arb_state_t              state;
    arb_owner_t              owner;
    arb_owner_t              winner;
    logic [ARB_STREAK_W-1:0] streak;
    logic [ARB_STREAK_W-1:0] streak_nxt;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;
    logic [DATA_W-1:0]       rd_data_q;
    logic                    if_ack_q;
    logic                    d_ack_q;
`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_cnt;
    logic       err_q;
`endif

    arb_pick #(.MAX_D_STREAK(MAX_D_STREAK)) u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .streak     (streak),
        .winner     (winner),
        .streak_nxt (streak_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            streak      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (winner != OWN_NONE) begin
                        state     <= ACCESS;
                        owner     <= winner;
                        streak    <= streak_nxt;
                        mem_req_q <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                        if (winner == OWN_D) begin
                            mem_we_q    <= bus.d_we;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) rd_data_q <= bus.mem_rdata;
                        if_ack_q  <= (owner == OWN_IF);
                        d_ack_q   <= (owner == OWN_D);
                        state     <= RESP;
`ifdef MEM_TIMEOUT_EN
                    end else if (wait_cnt == TMO_LAST) begin
                        // Abandon the access: owner still gets its ack, with zero data.
                        mem_req_q <= 1'b0;
                        rd_data_q <= '0;
                        err_q     <= 1'b1;
                        if_ack_q  <= (owner == OWN_IF);
                        d_ack_q   <= (owner == OWN_D);
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    owner    <= OWN_NONE;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;
`ifdef MEM_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, requester drivers,
// per-requester expected queues popped on each ack.
module tb_mem_port_arbiter;
  import cpu_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err;
  arb_state_t state_dbg;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [63:0] mem_arr [logic [63:0]];
  bit          mem_stall = 1'b0;
  int          mem_wait = 0;
  int          mem_wcnt = 0;
  logic        model_ack = 1'b0;
  logic [63:0] model_rdata = '0;
  logic        stray_ack = 1'b0;
  logic [63:0] stray_data = '0;

  assign bus.mem_ack   = model_ack | stray_ack;
  assign bus.mem_rdata = stray_ack ? stray_data : model_rdata;

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a[31:0], ~a[31:0]};
  endfunction

  initial begin : mem_model
    forever begin
      @(negedge clk);
      model_ack = 1'b0;
      if (!rst_n || !bus.mem_req) begin
        mem_wcnt = 0;
      end else if (!mem_stall) begin
        if (mem_wcnt >= mem_wait) begin
          model_ack = 1'b1;
          if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
          else model_rdata = mem_read(bus.mem_addr);
          mem_wcnt = 0;
        end else begin
          mem_wcnt++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_if_q[$];
  logic [63:0] exp_d_q[$];
  bit          exp_st_q[$];
  bit          grant_log[$];
  logic [63:0] exp_rd = '0;
  logic [63:0] mon_e;
  bit          mon_st;

  initial begin : ack_monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.if_ack) check("dual_ack", {63'b0, bus.d_ack}, 64'd0);
        if (bus.if_ack) begin
          grant_log.push_back(1'b0);
          if (exp_if_q.size() == 0) check("if_ack_unexpected", {63'b0, bus.if_ack}, 64'd0);
          else begin
            exp_rd = exp_if_q.pop_front();
            check("if_rd_data", bus.rd_data, exp_rd);
          end
        end
        if (bus.d_ack) begin
          grant_log.push_back(1'b1);
          if (exp_d_q.size() == 0) check("d_ack_unexpected", {63'b0, bus.d_ack}, 64'd0);
          else begin
            mon_e  = exp_d_q.pop_front();
            mon_st = exp_st_q.pop_front();
            if (!mon_st) exp_rd = mon_e;
            check(mon_st ? "st_rd_data_held" : "ld_rd_data", bus.rd_data, exp_rd);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input bit is_d, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? bus.d_ack : bus.if_ack) && n < 200);
    check(tag, {63'b0, (is_d ? bus.d_ack : bus.if_ack)}, 64'd1);
  endtask

  task automatic do_fetch(input logic [63:0] a);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    exp_if_q.push_back(mem_read(a));
    wait_ack(1'b0, "fetch_ack_seen");
    bus.if_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [63:0] a, input logic [63:0] wd);
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    exp_d_q.push_back(we ? 64'd0 : mem_read(a));
    exp_st_q.push_back(we);
    wait_ack(1'b1, "data_ack_seen");
    bus.d_req = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int n;
  int req_cycles;
  bit exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    mem_arr[64'h40] = 64'h8B02_0020;
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, IDLE);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_mem_req", {63'b0, bus.mem_req}, 64'd0);
    check("rst_rd_data", bus.rd_data, 64'd0);
    check("rst_err", {63'b0, err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone fetch, two memory wait cycles.
    mem_wait = 2;
    bus.if_addr = 64'h40;
    bus.if_req  = 1'b1;
    exp_if_q.push_back(mem_read(64'h40));
    n = 0; req_cycles = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.mem_req) begin
        req_cycles++;
        check("fetch_mem_we", {63'b0, bus.mem_we}, 64'd0);
        check("fetch_mem_addr", bus.mem_addr, 64'h40);
      end
    end while (!bus.if_ack && n < 50);
    check("fetch_ack_latency", n, 4);
    check("fetch_req_cycles", req_cycles, 3);
    check("fetch_rd_data", bus.rd_data, 64'h8B02_0020);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Lone store, zero-wait memory.
    mem_wait = 0;
    bus.d_we = 1'b1; bus.d_addr = 64'h100; bus.d_wdata = 64'hDEAD; bus.d_req = 1'b1;
    exp_d_q.push_back(64'd0);
    exp_st_q.push_back(1'b1);
    @(negedge clk);
    check("store_state", state_dbg, ACCESS);
    check("store_busy", {63'b0, busy}, 64'd1);
    check("store_mem_we", {63'b0, bus.mem_we}, 64'd1);
    check("store_mem_addr", bus.mem_addr, 64'h100);
    check("store_mem_wdata", bus.mem_wdata, 64'hDEAD);
    wait_ack(1'b1, "store_ack_seen");
    check("store_rd_unchanged", bus.rd_data, 64'h8B02_0020);
    bus.d_req = 1'b0;
    @(negedge clk);
    do_data(1'b0, 64'h100, 64'd0);
    check("load_back", bus.rd_data, 64'hDEAD);
    @(negedge clk);

    // Contention: both held continuously, data-first with forced fetch.
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          bus.if_addr = 64'h200 + 64'(i * 8);
          exp_if_q.push_back(mem_read(bus.if_addr));
          bus.if_req = 1'b1;
          wait_ack(1'b0, "cont_if_ack");
        end
        bus.if_req = 1'b0;
      end
      begin
        for (int j = 0; j < 8; j++) begin
          bus.d_we = 1'b0;
          bus.d_addr = 64'h300 + 64'(j * 8);
          exp_d_q.push_back(mem_read(bus.d_addr));
          exp_st_q.push_back(1'b0);
          bus.d_req = 1'b1;
          wait_ack(1'b1, "cont_d_ack");
        end
        bus.d_req = 1'b0;
      end
    join
    check("cont_grants", grant_log.size(), 10);
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      check($sformatf("cont_order_%0d", k), {63'b0, grant_log[k]}, {63'b0, exp_order[k]});
    @(negedge clk);

    // Reset while memory stalls in ACCESS; the held load is granted again afterwards.
    mem_stall = 1'b1;
    bus.d_we = 1'b0; bus.d_addr = 64'h500; bus.d_req = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_pre_state", state_dbg, ACCESS);
    check("midrst_pre_req", {63'b0, bus.mem_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", {63'b0, bus.mem_req}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_state", state_dbg, IDLE);
    exp_rd = '0;
    @(negedge clk);
    check("midrst_rd_data", bus.rd_data, 64'd0);
    mem_stall = 1'b0;
    exp_d_q.push_back(mem_read(64'h500));
    exp_st_q.push_back(1'b0);
    rst_n = 1'b1;
    wait_ack(1'b1, "midrst_regrant_ack");
    bus.d_req = 1'b0;
    @(negedge clk);

    // Stray mem_ack while idle must be ignored.
    stray_data = 64'hBAD0_BAD0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stray_if_ack", {63'b0, bus.if_ack}, 64'd0);
      check("stray_d_ack", {63'b0, bus.d_ack}, 64'd0);
    end
    check("stray_rd_data", bus.rd_data, exp_rd);
    check("stray_state", state_dbg, IDLE);

    // Random lone transactions.
    for (int r = 0; r < 8; r++) begin
      mem_wait = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0: do_fetch(64'({$urandom_range(0, 63), 3'b000}));
        1: do_data(1'b0, 64'({$urandom_range(0, 63), 3'b000}), 64'd0);
        default: do_data(1'b1, 64'({$urandom_range(0, 63), 3'b000}), {$urandom, $urandom});
      endcase
      @(negedge clk);
    end

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: access aborted after 8 ACCESS cycles.
    mem_stall = 1'b1;
    bus.if_addr = 64'h600;
    bus.if_req = 1'b1;
    exp_if_q.push_back(64'd0);
    n = 0; req_cycles = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.mem_req) req_cycles++;
    end while (!bus.if_ack && n < 50);
    check("tmo_req_cycles", req_cycles, 8);
    check("tmo_ack_latency", n, 9);
    check("tmo_err", {63'b0, err}, 64'd1);
    check("tmo_rd_zero", bus.rd_data, 64'd0);
    bus.if_req = 1'b0;
    mem_stall = 1'b0;
    @(negedge clk);
    do_data(1'b0, 64'h608, 64'd0);
    check("tmo_err_sticky", {63'b0, err}, 64'd1);
`else
    check("err_tied_low", {63'b0, err}, 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("end_if_q_empty", exp_if_q.size(), 0);
    check("end_d_q_empty", exp_d_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one variable-latency memory port between the instruction-fetch requester and the data requester (LDUR/STUR, driven by the decoder's MemReadEn/MemWrite).
- Sits between the CPU datapath and unified memory in the multicycle core.
- Sequences each access with a req/ack handshake on both sides.
- Applies data-first priority with an anti-starvation streak counter for fetch.

Parameters:
ADDR_W, 64, address width for requesters and memory
DATA_W, 64, data width for read and write data
MAX_D_STREAK, 4, max consecutive data grants while fetch pending before fetch is forced (range 1..15)
TIMEOUT_CYC, 255, cycles in ACCESS before abort; used only with MEM_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse; rd_data valid this cycle
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
d_we  in  1  1=store (STUR), 0=load (LDUR)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse; rd_data valid this cycle for loads
rd_data  out  DATA_W  registered read data, holds until next ack
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  one-cycle completion pulse; mem_rdata valid this cycle
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in ACCESS and RESP states
err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0. Streak counter=0. Owner=none.
- FSM states: IDLE, ACCESS, RESP.
- IDLE → ACCESS on the clock edge with any request pending.
  - Grant goes to data if d_req=1 and not (if_req=1 and streak==MAX_D_STREAK); otherwise to fetch.
  - mem_req/mem_we/mem_addr/mem_wdata are registered from the winner's inputs. mem_req rises the cycle after the request is seen.
  - Fetch grant forces mem_we=0.
- ACCESS: memory fields held stable. On mem_ack: capture mem_rdata into rd_data (store: rd_data unchanged), drop mem_req, go to RESP.
- RESP: one cycle. Owner's ack=1, other ack=0. Then → IDLE.
  - The served requester's req is ignored in this cycle; it must deassert or present a new request seen in IDLE.
- Minimum access = 3 cycles (IDLE, ACCESS with 0-wait mem_ack, RESP). Requester ack latency = memory latency + 2.
- Streak counter, updated at grant:
  - Data grant while if_req=1: streak+1, saturating at MAX_D_STREAK.
  - Any fetch grant: streak=0.
  - Data grant with if_req=0: streak=0.
- Simultaneous if_req and d_req with streak<MAX_D_STREAK: data wins.
- mem_ack outside ACCESS is ignored.
- Reset asserted mid-ACCESS: immediate return to IDLE, mem_req=0, no ack emitted. The memory side is reset by the same signal.
- Requester deasserting req before ack is a protocol violation. The arbiter still completes the access and emits the ack.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter cleared on entry to ACCESS.
  - When it reaches TIMEOUT_CYC without mem_ack: drop mem_req, set err=1 (sticky until reset), go to RESP, ack the owner with rd_data=0.
- Undefined: no counter. ACCESS waits indefinitely. err tied 0.

Decomposition:
- Shared package cpu_pkg:
  - enum arb_state_t {IDLE, ACCESS, RESP}
  - enum arb_owner_t {OWN_NONE, OWN_IF, OWN_D}
  - localparam ARB_STREAK_W=4
- Sub-module arb_pick: combinational winner select from if_req, d_req, streak, MAX_D_STREAK. Instantiated once.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x40, memory acks after 2 wait cycles with 0x8B020020 → mem_req high cycles 1–3 with mem_we=0, if_ack pulse at cycle 4, rd_data=0x8B020020.
- Lone store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD → mem_we=1, mem_wdata=0xDEAD, d_ack pulse, rd_data unchanged.
- Contention: if_req and d_req held continuously, MAX_D_STREAK=4, 0-wait memory → grant order D,D,D,D,IF,D,D,D,D,IF.
- Reset mid-access: reset=0 while in ACCESS → mem_req=0 and busy=0 immediately; no if_ack/d_ack; after release, pending d_req is re-granted.
- Stray mem_ack in IDLE → no ack pulses, rd_data unchanged.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=8, memory never acks → mem_req drops after 8 ACCESS cycles, err=1, owner acked with rd_data=0, err stays 1 on later accesses.
